// File: rtl/cam_pkg.sv
// cam_pkg: output-format and FSM encodings plus luma coefficients for the camera capture path
package cam_pkg;
  typedef enum logic [1:0] {MODE_444 = 2'd0, MODE_565 = 2'd1, MODE_Y8 = 2'd2, MODE_RSV = 2'd3} mode_e;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_VS = 2'd1, ACTIVE = 2'd2} state_e;
  localparam logic [7:0] Y_CR = 8'd77;
  localparam logic [7:0] Y_CG = 8'd150;
  localparam logic [7:0] Y_CB = 8'd29;
endpackage

// File: rtl/pix_capture_dbuf_if.sv
// pix_capture_dbuf_if: camera byte stream in, frame-buffer write port out
interface pix_capture_dbuf_if #(parameter int ADDR_W = 20);
  logic i_vsync;
  logic i_href;
  logic [7:0] i_pix_byte;
  logic o_wren;
  logic [15:0] o_wdata;
  logic [ADDR_W-1:0] o_waddr;
  modport master (input i_vsync, i_href, i_pix_byte, output o_wren, o_wdata, o_waddr);
  modport slave (output i_vsync, i_href, i_pix_byte, input o_wren, o_wdata, o_waddr);
endinterface

// File: rtl/pix_capture_dbuf_conv.sv
// pix_fmt_conv: two-stage RGB565 -> RGB444/RGB565/Y8 converter carrying a sideband tag
module pix_fmt_conv import cam_pkg::*; #(parameter int SW = 20) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_v,
  input  logic [15:0] in_pix,
  input  mode_e mode,
  input  logic [SW-1:0] in_side,
  output logic out_v,
  output logic [15:0] out_data,
  output logic [SW-1:0] out_side
);
  logic s1_v;
  logic [15:0] s1_pix, pr, pg, pb, y_sum;
  mode_e s1_mode;
  logic [SW-1:0] s1_side;
  logic [7:0] r8, g8, b8;
  always_comb begin
    r8 = {in_pix[15:11], in_pix[15:13]};
    g8 = {in_pix[10:5], in_pix[10:9]};
    b8 = {in_pix[4:0], in_pix[4:2]};
    y_sum = pr + pg + pb;
  end
  // coefficients sum to 256, so the luma sum never exceeds 16 bits
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_v <= 1'b0;
      s1_pix <= '0;
      s1_mode <= MODE_444;
      s1_side <= '0;
      pr <= '0;
      pg <= '0;
      pb <= '0;
      out_v <= 1'b0;
      out_data <= '0;
      out_side <= '0;
    end else begin
      s1_v <= in_v & ~flush;
      out_v <= s1_v & ~flush;
      if (in_v) begin
        s1_pix <= in_pix;
        s1_mode <= mode;
        s1_side <= in_side;
        pr <= 16'(Y_CR) * 16'(r8);
        pg <= 16'(Y_CG) * 16'(g8);
        pb <= 16'(Y_CB) * 16'(b8);
      end
      if (s1_v) begin
        out_side <= s1_side;
        out_data <= s1_mode == MODE_444 ? {4'b0, s1_pix[15:12], s1_pix[10:7], s1_pix[4:1]} :
                    s1_mode == MODE_Y8 ? {8'b0, y_sum[15:8]} : s1_pix;
      end
    end
endmodule

// File: rtl/pix_capture_dbuf.sv
// pix_capture_dbuf: captures camera byte pairs into a double-buffered frame store
module pix_capture_dbuf import cam_pkg::*; #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int ADDR_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic [1:0] i_mode,
  input  logic i_decim,
  pix_capture_dbuf_if.master bus,
  output logic o_bank,
  output logic o_rd_bank,
  output logic o_frame_done,
  output logic [15:0] o_frame_cnt,
  output logic o_err
);
  localparam int PW = $clog2(H_RES + 1);
  localparam int LW = $clog2(V_RES + 1);
  localparam logic [PW-1:0] PX_MAX = PW'(H_RES);
  localparam logic [LW-1:0] LN_MAX = LW'(V_RES);
  localparam logic [ADDR_W-1:0] BANK1 = ADDR_W'(H_RES * V_RES);
  state_e state, nxt;
  mode_e mode_q;
  logic decim_q, vs_q, hr_q, ph, bad, cap_v;
  logic [7:0] hi;
  logic [15:0] cap_pix;
  logic [PW-1:0] px;
  logic [LW-1:0] ln;
  logic [ADDR_W-1:0] idx, cap_addr;
  logic [1:0] pend;
  logic vs_fall, vs_rise, arm, start, act, fin, pix_done, over, line_end, wr_ok, good, err_set;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = !i_en ? IDLE :
          state == IDLE ? WAIT_VS :
          state == WAIT_VS ? (vs_fall ? ACTIVE : WAIT_VS) :
          (vs_rise ? WAIT_VS : ACTIVE);
  always_comb begin
    arm = state == IDLE && i_en;
    start = state == WAIT_VS && nxt == ACTIVE;
    act = state == ACTIVE && i_en;
    fin = act && vs_rise;
  end
  always_comb begin
    vs_fall = vs_q & ~bus.i_vsync;
    vs_rise = ~vs_q & bus.i_vsync;
    pix_done = act & bus.i_href & ph;
    over = pix_done & ((px == PX_MAX) | (ln == LN_MAX));
    line_end = act & ~bus.i_href & hr_q;
    wr_ok = pix_done & ~over & (~decim_q | ~(px[0] | ln[0]));
    good = (ln == LN_MAX) & ~bad;
    err_set = over | (line_end & (ph | (ln == LN_MAX))) | (fin & ~good);
  end
  // px and ln saturate at the resolution; overflow is tracked by bad instead
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vs_q <= 1'b0;
      hr_q <= 1'b0;
      mode_q <= MODE_444;
      decim_q <= 1'b0;
      ph <= 1'b0;
      hi <= '0;
      px <= '0;
      ln <= '0;
      idx <= '0;
      bad <= 1'b0;
      cap_v <= 1'b0;
      cap_pix <= '0;
      cap_addr <= '0;
    end else begin
      vs_q <= bus.i_vsync;
      hr_q <= bus.i_href;
      cap_v <= wr_ok;
      if (start) begin
        mode_q <= mode_e'(i_mode);
        decim_q <= i_decim;
        ph <= 1'b0;
        px <= '0;
        ln <= '0;
        idx <= '0;
        bad <= 1'b0;
      end else if (act && bus.i_href) begin
        ph <= ~ph;
        if (!ph) hi <= bus.i_pix_byte;
        if (pix_done && !over) px <= px + 1'b1;
        if (over) bad <= 1'b1;
        if (wr_ok) begin
          cap_pix <= {hi, bus.i_pix_byte};
          cap_addr <= (o_bank ? BANK1 : '0) + idx;
          idx <= idx + 1'b1;
        end
      end else if (line_end) begin
        ph <= 1'b0;
        px <= '0;
        if (ln != LN_MAX) ln <= ln + 1'b1;
        if (ph || px != PX_MAX || ln == LN_MAX) bad <= 1'b1;
      end
    end
  // commit waits out the converter latency so the last write precedes the bank swap
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend <= '0;
      o_bank <= 1'b0;
      o_rd_bank <= 1'b1;
      o_frame_done <= 1'b0;
      o_frame_cnt <= '0;
      o_err <= 1'b0;
    end else begin
      pend <= i_en ? {pend[0], fin & good} : 2'b00;
      o_frame_done <= pend[1] & i_en;
      if (pend[1] && i_en) begin
        o_rd_bank <= o_bank;
        o_bank <= ~o_bank;
        o_frame_cnt <= o_frame_cnt + 1'b1;
      end
      o_err <= arm ? 1'b0 : (o_err | err_set);
    end
  pix_fmt_conv #(.SW(ADDR_W)) u_conv (
    .clk(clk),
    .rst(rst),
    .flush(~i_en),
    .in_v(cap_v),
    .in_pix(cap_pix),
    .mode(mode_q),
    .in_side(cap_addr),
    .out_v(bus.o_wren),
    .out_data(bus.o_wdata),
    .out_side(bus.o_waddr)
  );
endmodule

// File: tb/tb_pix_capture_dbuf.sv
// tb_pix_capture_dbuf: directed frame table plus latency, enable-drop and reset sequences
module tb_pix_capture_dbuf;
  import cam_pkg::*;
  typedef struct {
    logic [1:0] mode; logic decim; logic ramp; logic [15:0] pix; int bad_line;
    int n_wr; int base; logic [15:0] dat; int done; logic bank; logic [15:0] cnt; logic err;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, i_en = 1'b0, i_decim = 1'b0;
  logic [1:0] i_mode = 2'd0;
  logic o_bank, o_rd_bank, o_frame_done, o_err;
  logic [15:0] o_frame_cnt;
  int n_chk = 0, n_bad = 0, cyc = 0, last_wr = 0, done_at = 0, n_done = 0, pn = 0, hit = 0;
  logic [19:0] wa[$];
  logic [15:0] wd[$];
  vec_t tbl[9];
  vec_t fin_vec;
  pix_capture_dbuf_if #(.ADDR_W(20)) bus();
  pix_capture_dbuf #(.H_RES(8), .V_RES(4), .ADDR_W(20)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_mode(i_mode), .i_decim(i_decim), .bus(bus),
    .o_bank(o_bank), .o_rd_bank(o_rd_bank), .o_frame_done(o_frame_done),
    .o_frame_cnt(o_frame_cnt), .o_err(o_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (bus.o_wren) begin
      wa.push_back(bus.o_waddr);
      wd.push_back(bus.o_wdata);
      last_wr = cyc;
    end
    if (o_frame_done) begin
      n_done++;
      done_at = cyc;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic step(input logic vs, input logic hr, input logic [7:0] b);
    bus.i_vsync = vs;
    bus.i_href = hr;
    bus.i_pix_byte = b;
    @(negedge clk);
  endtask
  task automatic send_lines(input logic ramp, input logic [15:0] pix, input int bad_line);
    logic [15:0] val;
    pn = 0;
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < (l == bad_line ? 9 : 8); p++) begin
        val = ramp ? 16'(pn) : pix;
        step(1'b0, 1'b1, val[15:8]);
        step(1'b0, 1'b1, val[7:0]);
        pn++;
      end
      repeat (3) step(1'b0, 1'b0, 8'h00);
    end
  endtask
  task automatic send_frame(input logic ramp, input logic [15:0] pix, input int bad_line);
    repeat (2) step(1'b1, 1'b0, 8'h00);
    repeat (2) step(1'b0, 1'b0, 8'h00);
    send_lines(ramp, pix, bad_line);
    repeat (8) step(1'b1, 1'b0, 8'h00);
  endtask
  task automatic run_vec(input int id, input vec_t v);
    i_mode = v.mode;
    i_decim = v.decim;
    wa.delete();
    wd.delete();
    n_done = 0;
    send_frame(v.ramp, v.pix, v.bad_line);
    chk($sformatf("v%0d n_wr", id), 32'(wa.size()), 32'(v.n_wr));
    for (int k = 0; k < wa.size() && k < v.n_wr; k++)
      chk($sformatf("v%0d wr%0d addr_data", id, k), {wa[k][15:0], wd[k]},
          {16'(v.base + k), v.ramp ? 16'(k) : v.dat});
    chk($sformatf("v%0d done_cnt", id), 32'(n_done), 32'(v.done));
    if (v.done != 0) chk($sformatf("v%0d done_after_wr", id), 32'(done_at > last_wr), 32'd1);
    chk($sformatf("v%0d bank", id), 32'(o_bank), 32'(v.bank));
    chk($sformatf("v%0d rd_bank", id), 32'(o_rd_bank), 32'(!v.bank));
    chk($sformatf("v%0d frame_cnt", id), 32'(o_frame_cnt), 32'(v.cnt));
    chk($sformatf("v%0d err", id), 32'(o_err), 32'(v.err));
  endtask
  initial begin
    tbl[0] = '{2'd1, 1'b0, 1'b1, 16'h0000, -1, 32, 0,  16'h0000, 1, 1'b1, 16'd1, 1'b0};
    tbl[1] = '{2'd1, 1'b0, 1'b1, 16'h0000, -1, 32, 32, 16'h0000, 1, 1'b0, 16'd2, 1'b0};
    tbl[2] = '{2'd2, 1'b1, 1'b0, 16'hFFFF, -1, 8,  0,  16'h00FF, 1, 1'b1, 16'd3, 1'b0};
    tbl[3] = '{2'd0, 1'b0, 1'b0, 16'hF81F, -1, 32, 32, 16'h0F0F, 1, 1'b0, 16'd4, 1'b0};
    tbl[4] = '{2'd1, 1'b0, 1'b0, 16'h1234, 1,  32, 0,  16'h1234, 0, 1'b0, 16'd4, 1'b1};
    tbl[5] = '{2'd1, 1'b0, 1'b1, 16'h0000, -1, 32, 0,  16'h0000, 1, 1'b1, 16'd5, 1'b1};
    tbl[6] = '{2'd3, 1'b0, 1'b0, 16'hABCD, -1, 32, 32, 16'hABCD, 1, 1'b0, 16'd6, 1'b1};
    tbl[7] = '{2'd2, 1'b0, 1'b0, 16'hF81F, -1, 32, 0,  16'h0069, 1, 1'b1, 16'd7, 1'b1};
    tbl[8] = '{2'd0, 1'b1, 1'b0, 16'h07E0, -1, 8,  32, 16'h00F0, 1, 1'b0, 16'd8, 1'b1};
    fin_vec = '{2'd1, 1'b0, 1'b1, 16'h0000, -1, 32, 0, 16'h0000, 1, 1'b1, 16'd1, 1'b0};
    bus.i_vsync = 1'b1;
    bus.i_href = 1'b0;
    bus.i_pix_byte = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst wren", 32'(bus.o_wren), 32'd0);
    chk("rst wdata", 32'(bus.o_wdata), 32'd0);
    chk("rst waddr", 32'(bus.o_waddr), 32'd0);
    chk("rst bank", 32'(o_bank), 32'd0);
    chk("rst rd_bank", 32'(o_rd_bank), 32'd1);
    chk("rst done", 32'(o_frame_done), 32'd0);
    chk("rst frame_cnt", 32'(o_frame_cnt), 32'd0);
    chk("rst err", 32'(o_err), 32'd0);
    i_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) run_vec(i, tbl[i]);
    // RGB444 write must appear exactly two edges after the completing byte
    i_mode = 2'd0;
    i_decim = 1'b0;
    repeat (2) step(1'b1, 1'b0, 8'h00);
    repeat (2) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hF8);
    bus.i_pix_byte = 8'h1F;
    @(posedge clk); #1;
    bus.i_href = 1'b0;
    chk("lat +0 wren", 32'(bus.o_wren), 32'd0);
    @(posedge clk); #1;
    chk("lat +1 wren", 32'(bus.o_wren), 32'd0);
    @(posedge clk); #1;
    chk("lat +2 wren", 32'(bus.o_wren), 32'd1);
    chk("lat +2 wdata", 32'(bus.o_wdata), 32'h0F0F);
    @(posedge clk); #1;
    chk("lat +3 wren", 32'(bus.o_wren), 32'd0);
    @(negedge clk);
    repeat (8) step(1'b1, 1'b0, 8'h00);
    chk("short frame err", 32'(o_err), 32'd1);
    // drop enable on the tenth pixel's completing byte
    i_mode = 2'd1;
    wa.delete();
    wd.delete();
    n_done = 0;
    repeat (2) step(1'b1, 1'b0, 8'h00);
    repeat (2) step(1'b0, 1'b0, 8'h00);
    for (int p = 0; p < 8; p++) begin
      step(1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b1, 8'(p));
    end
    repeat (3) step(1'b0, 1'b0, 8'h00);
    for (int p = 0; p < 2; p++) begin
      step(1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b1, 8'(p));
    end
    i_en = 1'b0;
    bus.i_href = 1'b0;
    @(posedge clk); #1;
    hit = 0;
    repeat (6) begin
      if (bus.o_wren) hit++;
      @(posedge clk); #1;
    end
    chk("en_drop late writes", 32'(hit), 32'd0);
    chk("en_drop n_wr", 32'(wa.size()), 32'd9);
    chk("en_drop state", 32'(dut.state), 32'(IDLE));
    chk("en_drop bank", 32'(o_bank), 32'd0);
    chk("en_drop done", 32'(n_done), 32'd0);
    @(negedge clk);
    i_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rearm err clear", 32'(o_err), 32'd0);
    // reset mid-frame, then lines without a new vsync edge must not be captured
    repeat (2) step(1'b1, 1'b0, 8'h00);
    repeat (2) step(1'b0, 1'b0, 8'h00);
    for (int p = 0; p < 8; p++) begin
      step(1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b1, 8'(p));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.i_href = 1'b0;
    chk("mid rst wren", 32'(bus.o_wren), 32'd0);
    chk("mid rst bank", 32'(o_bank), 32'd0);
    chk("mid rst rd_bank", 32'(o_rd_bank), 32'd1);
    chk("mid rst frame_cnt", 32'(o_frame_cnt), 32'd0);
    wa.delete();
    wd.delete();
    send_lines(1'b1, 16'h0000, -1);
    chk("no vsync n_wr", 32'(wa.size()), 32'd0);
    run_vec(9, fin_vec);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/pix_capture_dbuf.md
PIX_CAPTURE_DBUF -- requirements
Module: pix_capture_dbuf

Interface
REQ-001 Parameter H_RES, default 640, active pixels per line; SHALL be even.
REQ-002 Parameter V_RES, default 480, active lines per frame; SHALL be even.
REQ-003 Parameter ADDR_W, default 20, write-address width; SHALL satisfy 2^ADDR_W >= 2*H_RES*V_RES.
REQ-004 clk  in  1  capture clock (camera pixel clock); reset rst, asynchronous, active-high; clock clk.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 i_en  in  1  capture enable.
REQ-007 i_mode  in  2  output format: 0 RGB444, 1 RGB565, 2 Y8, 3 reserved (treated as 1).
REQ-008 i_decim  in  1  0 full resolution, 1 2x2 decimation.
REQ-009 i_vsync / i_href / i_pix_byte  in  1/1/8  camera frame sync (high = blanking), line valid, data byte.
REQ-010 o_wren / o_wdata / o_waddr  out  1/16/ADDR_W  frame-buffer write strobe, pixel, word address.
REQ-011 o_bank / o_rd_bank  out  1/1  bank being written / last completed bank for the display reader.
REQ-012 o_frame_done / o_frame_cnt / o_err  out  1/16/1  completion pulse, completed-frame count, sticky error.

Function
REQ-013 FSM states: IDLE, WAIT_VS, ACTIVE; IDLE->WAIT_VS when i_en=1; WAIT_VS->ACTIVE on i_vsync falling edge; ACTIVE->WAIT_VS on i_vsync rising edge; any state->IDLE when i_en=0.
REQ-014 i_mode and i_decim SHALL be latched on WAIT_VS->ACTIVE and held for the whole frame.
REQ-015 In ACTIVE with i_href=1, bytes SHALL pair first=P[15:8], second=P[7:0] (RGB565); a pixel completes on the second byte.
REQ-016 Conversion: RGB444 -> {4'b0,R[4:1],G[5:2],B[4:1]}; RGB565 -> P unchanged; Y8 -> {8'b0,(77*R8+150*G8+29*B8)>>8}, R8={R,R[4:2]}, G8={G,G[5:4]}, B8={B,B[4:2]}.
REQ-017 o_wren SHALL assert exactly 2 clk after the completing byte is sampled, for one cycle, in every mode.
REQ-018 o_waddr = bank base (0 or H_RES*V_RES) + sequential write index, generated by incrementing counter, no multiplier.
REQ-019 With i_decim=1, only even pixels of even lines (0-based) SHALL be written, index running 0..(H_RES/2)*(V_RES/2)-1.
REQ-020 Line count SHALL increment on each i_href falling edge in ACTIVE.
REQ-021 Pixels beyond H_RES in a line and lines beyond V_RES SHALL not be written and SHALL set o_err.
REQ-022 An odd byte count at i_href falling SHALL discard the partial byte and set o_err.
REQ-023 Frame good = exactly V_RES lines each of exactly H_RES pixels.
REQ-024 On i_vsync rising in ACTIVE with a good frame: o_rd_bank<=o_bank, o_bank toggles, o_frame_cnt increments (wraps 0xFFFF->0), o_frame_done pulses one cycle, all in the same cycle, after the final write has issued.
REQ-025 On a bad frame: no bank toggle, no count, no pulse; o_err set; next frame rewrites the same bank from index 0.
REQ-026 i_en=0 mid-frame: o_wren low from the next cycle, in-flight pipeline writes dropped, no bank toggle.
REQ-027 o_err SHALL clear only on reset or on an IDLE->WAIT_VS transition.

Reset
REQ-028 On rst: state IDLE, o_wren=0, o_wdata=0, o_waddr=0, o_bank=0, o_rd_bank=1, o_frame_done=0, o_frame_cnt=0, o_err=0, all counters and pipeline registers 0.
REQ-029 Reset mid-frame SHALL discard the frame; capture resumes only after a fresh i_vsync falling edge.

Structure
REQ-030 Package cam_pkg SHALL hold mode encodings, FSM state encoding, and the Y8 coefficients.
REQ-031 Sub-module pix_fmt_conv SHALL implement REQ-016 as a fixed 2-stage pipeline.

Verification (H_RES=8, V_RES=4)
REQ-032 Good RGB565 frame, pixel n=n -> 32 writes, addr 0..31, data 0..31; o_frame_done pulse; o_bank=1, o_rd_bank=0, o_frame_cnt=1.
REQ-033 Second good frame -> addr 32..63, o_bank=0, o_rd_bank=1, o_frame_cnt=2.
REQ-034 i_decim=1, mode Y8, all pixels 0xFFFF -> 8 writes, data 0x00FF, addr 0..7.
REQ-035 Line with 9 pixels -> 8 writes on that line, o_err=1, no o_frame_done, bank unchanged.
REQ-036 i_en dropped after 10 pixels -> no writes after the next cycle, o_bank unchanged, state IDLE.
REQ-037 RGB444, pixel 0xF81F -> o_wdata 0x0F0F, 2 clk after the second byte.
